// File: rtl/des_multi_wrapper.sv
// Multi-core DES search wrapper: fans a region out to NUM_CORES des_block cores,
// returns their results lowest-index-first and exposes a per-core test port.

// Behavioural des_block core: search latency and counter derive from its region.
module des_block #(
    parameter int unsigned REGION_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REGION_W-1:0] region_select,
    input  logic                start,
    input  logic                restart_block,
    input  logic                test_enabled,
    input  logic                test_advance,
    output logic                done,
    output logic [47:0]         counter,
    output logic                test_data_valid,
    output logic [63:0]         ciphertext_out
);
    logic        r_running;
    logic        r_done;
    logic        r_tvalid;
    logic [31:0] r_count;
    logic [7:0]  r_step;
    logic [3:0]  w_lat;

    assign w_lat = 4'(4'(region_select) * 4'd5);

    always_ff @(posedge clk) begin
        if (!rst_n || restart_block) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tvalid  <= 1'b0;
            r_count   <= '0;
            r_step    <= '0;
        end else begin
            if (start) begin
                r_running <= 1'b1;
                r_done    <= 1'b0;
                r_count   <= '0;
            end else if (r_running) begin
                if (r_count == 32'(w_lat)) begin
                    r_done    <= 1'b1;
                    r_running <= 1'b0;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end
            if (test_enabled && test_advance) begin
                r_step   <= r_step + 8'd1;
                r_tvalid <= 1'b1;
            end
        end
    end

    assign done            = r_done;
    assign counter         = {16'(region_select), r_count};
    assign test_data_valid = r_tvalid;
    assign ciphertext_out  = {16'(region_select), 40'd0, r_step};
endmodule

module des_multi_wrapper #(
    parameter  int unsigned NUM_CORES = 4,
    parameter  int unsigned REGION_W  = 16,
    parameter  int unsigned CMD_W     = 4,
    localparam int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CMD_W-1:0]    cmd,
    input  logic                cmd_valid,
    output logic                cmd_read,
    input  logic [REGION_W-1:0] region_base,
    input  logic                advance_test_cmd,
    input  logic [IDX_W-1:0]    test_sel,
    output logic                test_res_ready,
    output logic [63:0]         test_ciphertext,
    output logic                result_valid,
    input  logic                result_ack,
    output logic [IDX_W-1:0]    result_core,
    output logic [63:0]         result_counter,
    output logic                busy,
    output logic                all_done
);
    localparam logic [CMD_W-1:0] CMD_READ_REGION = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_START       = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_TEST_MODE   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_RESTART     = CMD_W'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DONE, S_TEST, S_ADVANCE, S_RESTART
    } state_t;

    state_t                r_state;
    logic [REGION_W-1:0]   r_region;
    logic [NUM_CORES-1:0]  r_done_seen;
    logic [NUM_CORES-1:0]  r_pending;
    logic [47:0]           r_res_cnt [NUM_CORES];
    logic                  r_cmd_read;
    logic                  r_busy;
    logic                  r_result_valid;
    logic [IDX_W-1:0]      r_result_core;
    logic [47:0]           r_result_counter;
    logic                  r_all_done;
    logic                  r_start;
    logic                  r_restart;
    logic                  r_test_en;
    logic [NUM_CORES-1:0]  r_test_adv;

    logic [REGION_W-1:0]   w_region [NUM_CORES];
    logic [NUM_CORES-1:0]  w_done;
    logic [NUM_CORES-1:0]  w_tdv;
    logic [47:0]           w_cnt [NUM_CORES];
    logic [63:0]           w_ct [NUM_CORES];
    logic [IDX_W-1:0]      w_sel;
    logic                  w_restart_cmd;
    logic [NUM_CORES-1:0]  w_capture;
    logic [NUM_CORES-1:0]  w_ack_vec;
    logic [NUM_CORES-1:0]  w_pending_nxt;
    logic [47:0]           w_res_cnt_nxt [NUM_CORES];
    logic [IDX_W-1:0]      w_pick_idx;
    logic [47:0]           w_pick_cnt;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign w_region[i] = r_region + REGION_W'(i);
        des_block #(.REGION_W(REGION_W)) u_core (
            .clk             (clk),
            .rst_n           (rst_n),
            .region_select   (w_region[i]),
            .start           (r_start),
            .restart_block   (r_restart),
            .test_enabled    (r_test_en),
            .test_advance    (r_test_adv[i]),
            .done            (w_done[i]),
            .counter         (w_cnt[i]),
            .test_data_valid (w_tdv[i]),
            .ciphertext_out  (w_ct[i])
        );
    end

    assign w_sel         = (32'(test_sel) < NUM_CORES) ? test_sel : '0;
    assign w_restart_cmd = cmd_valid && (cmd == CMD_RESTART);

    // Result bookkeeping for the coming cycle: new captures merge with the acked slot cleared.
    always_comb begin
        w_capture  = '0;
        w_ack_vec  = '0;
        w_pick_idx = '0;
        if (r_state == S_RUN)
            w_capture = w_done & ~r_done_seen;
        if ((r_state == S_RUN || r_state == S_DONE) && result_ack && r_result_valid)
            w_ack_vec[r_result_core] = 1'b1;
        w_pending_nxt = (r_pending & ~w_ack_vec) | w_capture;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--)
            if (w_pending_nxt[i]) w_pick_idx = IDX_W'(i);
        for (int i = 0; i < int'(NUM_CORES); i++)
            w_res_cnt_nxt[i] = w_capture[i] ? w_cnt[i] : r_res_cnt[i];
    end

    assign w_pick_cnt = w_res_cnt_nxt[w_pick_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_region         <= '0;
            r_done_seen      <= '0;
            r_pending        <= '0;
            for (int i = 0; i < int'(NUM_CORES); i++) r_res_cnt[i] <= '0;
            r_cmd_read       <= 1'b0;
            r_busy           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_core    <= '0;
            r_result_counter <= '0;
            r_all_done       <= 1'b0;
            r_start          <= 1'b0;
            r_restart        <= 1'b0;
            r_test_en        <= 1'b0;
            r_test_adv       <= '0;
        end else begin
            r_cmd_read       <= 1'b0;
            r_start          <= 1'b0;
            r_restart        <= 1'b0;
            r_test_adv       <= '0;
            r_result_valid   <= 1'b0;
            r_result_core    <= '0;
            r_result_counter <= '0;
            r_all_done       <= 1'b0;
            if (w_restart_cmd && (r_state == S_IDLE || r_state == S_RUN ||
                                  r_state == S_DONE || r_state == S_TEST)) begin
                r_state     <= S_RESTART;
                r_cmd_read  <= 1'b1;
                r_restart   <= 1'b1;
                r_busy      <= 1'b0;
                r_test_en   <= 1'b0;
                r_done_seen <= '0;
                r_pending   <= '0;
                for (int i = 0; i < int'(NUM_CORES); i++) r_res_cnt[i] <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_cmd_read <= 1'b1;
                            case (cmd)
                                CMD_READ_REGION: r_state <= S_LOAD;
                                CMD_START: begin
                                    r_state     <= S_START;
                                    r_start     <= 1'b1;
                                    r_busy      <= 1'b1;
                                    r_done_seen <= '0;
                                    r_pending   <= '0;
                                end
                                CMD_TEST_MODE: begin
                                    r_state   <= S_TEST;
                                    r_test_en <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_LOAD: begin
                        r_region <= region_base;
                        r_state  <= S_IDLE;
                    end
                    S_START: r_state <= S_RUN;
                    S_RUN, S_DONE: begin
                        r_done_seen      <= r_done_seen | w_capture;
                        r_pending        <= w_pending_nxt;
                        for (int i = 0; i < int'(NUM_CORES); i++) r_res_cnt[i] <= w_res_cnt_nxt[i];
                        r_result_valid   <= |w_pending_nxt;
                        r_result_core    <= w_pick_idx;
                        r_result_counter <= w_pick_cnt;
                        if (r_state == S_DONE) begin
                            r_all_done <= ~|w_pending_nxt;
                        end else if (&r_done_seen) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_all_done <= ~|w_pending_nxt;
                        end
                    end
                    S_TEST: begin
                        if (advance_test_cmd) begin
                            r_state           <= S_ADVANCE;
                            r_test_adv[w_sel] <= 1'b1;
                        end
                    end
                    S_ADVANCE: r_state <= S_TEST;
                    S_RESTART: r_state <= S_IDLE;
                    default:   r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_read        = r_cmd_read;
    assign busy            = r_busy;
    assign result_valid    = r_result_valid;
    assign result_core     = r_result_core;
    assign result_counter  = {16'd0, r_result_counter};
    assign all_done        = r_all_done;
    assign test_res_ready  = (r_state == S_TEST) && w_tdv[w_sel];
    assign test_ciphertext = w_ct[w_sel];
endmodule
